sysbus_arbiter: RTL and testbench

- Sole owner of the shared Sysbus master port; sits between the instruction cache (client 0), the data cache (client 1) and the top-level bus pins.
- Grants the bus to one cache at a time and holds the grant until that client's full Sysbus transaction completes.
- Routes the owner's request signals onto the bus and the bus response back to the owner only.

---
 rtl/sysbus_pkg.sv | 32 +++
 rtl/sysbus_beat_counter.sv | 53 +++++
 rtl/sysbus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sysbus_pkg
// Purpose : Shared types and constants for the Sysbus arbiter and the cache
//           clients that talk through it.
// Contents: arb_state_t   - arbiter FSM state encoding
//           CLIENT_*      - client index of each cache on the arbiter
//           DEF_*         - default bus geometry
//           TAG_WRITE_BIT - request-tag bit that marks a write burst
// Revision: 1.0 - initial release
// ============================================================================
package sysbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RRESP = 2'd3
    } arb_state_t;

    localparam int CLIENT_ICACHE = 0;
    localparam int CLIENT_DCACHE = 1;

    localparam int DEF_BUS_DATA_WIDTH = 64;
    localparam int DEF_BUS_TAG_WIDTH  = 13;
    localparam int DEF_BURST_BEATS    = 8;   // 64-byte line over a 64-bit bus

    localparam int TAG_WRITE_BIT = DEF_BUS_TAG_WIDTH - 1;

endpackage : sysbus_pkg
`default_nettype wire

// File: rtl/sysbus_beat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sysbus_beat_counter
// Purpose : Counts accepted data beats of one Sysbus burst and flags the
//           final beat.
// Ports   : clk     - clock
//           reset   - synchronous, active-high reset (clears the count)
//           clr_i   - clear the count (start of a new burst)
//           inc_i   - one beat accepted this cycle
//           last_o  - count currently sits on beat BURST_BEATS-1, so an
//                     inc_i in this cycle completes the burst
// Revision: 1.0 - initial release
// ============================================================================
module sysbus_beat_counter
    import sysbus_pkg::*;
#(
    parameter int BURST_BEATS = DEF_BURST_BEATS
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    // One extra bit of headroom so the counter never wraps inside a burst.
    localparam int CNT_W = $clog2(BURST_BEATS) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CNT_W'(BURST_BEATS - 1));

endmodule : sysbus_beat_counter
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sysbus_arbiter
// Purpose : Sole master of the shared Sysbus port. Grants the bus to the
//           icache (client 0) or dcache (client 1) one at a time, holds the
//           grant for a full burst transaction and steers request/response
//           traffic between the owner and the bus pins.
// Ports   : clk, reset             - clock, synchronous active-high reset
//           bid[1:0]               - per-client bus request
//           grant[1:0]             - registered one-hot (or zero) ownership
//           c_reqcyc/c_req/c_reqtag- per-client request side
//           c_respack              - per-client response acknowledge
//           c_reqack/c_respcyc     - bus handshakes routed to the owner only
//           c_resp/c_resptag       - bus response, broadcast
//           bus_*                  - Sysbus master pins
// Revision: 1.0 - initial release
// ============================================================================
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = DEF_BUS_TAG_WIDTH,
    parameter int BURST_BEATS    = DEF_BURST_BEATS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    bid,
    output logic [1:0]                    grant,
    input  logic [1:0]                    c_reqcyc,
    input  logic [2*BUS_DATA_WIDTH-1:0]   c_req,
    input  logic [2*BUS_TAG_WIDTH-1:0]    c_reqtag,
    input  logic [1:0]                    c_respack,
    output logic [1:0]                    c_reqack,
    output logic [1:0]                    c_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]     c_resp,
    output logic [BUS_TAG_WIDTH-1:0]      c_resptag,
    output logic                          bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]     bus_req,
    output logic [BUS_TAG_WIDTH-1:0]      bus_reqtag,
    output logic                          bus_respack,
    input  logic                          bus_reqack,
    input  logic                          bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]     bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]      bus_resptag
);

    // Write bit of the tag follows the instantiated tag width.
    localparam int WR_BIT = BUS_TAG_WIDTH - 1;

    arb_state_t  state_q;
    logic [1:0]  grant_q;
    logic        last_owner_q;

    logic                       w_granted;
    logic                       w_owner;
    logic                       w_sel_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]  w_sel_req;
    logic [BUS_TAG_WIDTH-1:0]   w_sel_reqtag;
    logic                       w_sel_respack;
    logic                       w_resp_phase;
    logic                       w_req_acc;
    logic                       w_resp_acc;
    logic                       w_cnt_clr;
    logic                       w_cnt_inc;
    logic                       w_cnt_last;
    logic                       w_win_idx;

    // ------------------------------------------------------------------
    // Owner selection and routing. grant_q is one-hot, so its upper bit
    // is the owner's client index whenever a grant is held.
    // ------------------------------------------------------------------
    assign w_granted     = |grant_q;
    assign w_owner       = grant_q[1];
    assign w_sel_reqcyc  = w_owner ? c_reqcyc[1]  : c_reqcyc[0];
    assign w_sel_req     = w_owner ? c_req[2*BUS_DATA_WIDTH-1:BUS_DATA_WIDTH]
                                   : c_req[BUS_DATA_WIDTH-1:0];
    assign w_sel_reqtag  = w_owner ? c_reqtag[2*BUS_TAG_WIDTH-1:BUS_TAG_WIDTH]
                                   : c_reqtag[BUS_TAG_WIDTH-1:0];
    assign w_sel_respack = w_owner ? c_respack[1] : c_respack[0];
    assign w_resp_phase  = (state_q == RRESP);

    assign bus_reqcyc  = w_granted & w_sel_reqcyc;
    assign bus_req     = w_granted ? w_sel_req    : '0;
    assign bus_reqtag  = w_granted ? w_sel_reqtag : '0;
    // Responses are only meaningful while a read burst is in flight; a
    // stray response in any other state is neither forwarded nor acked.
    assign bus_respack = w_resp_phase & w_sel_respack;

    assign c_reqack  = bus_reqack ? grant_q : 2'b00;
    assign c_respcyc = (w_resp_phase & bus_respcyc) ? grant_q : 2'b00;
    assign c_resp    = bus_resp;
    assign c_resptag = bus_resptag;
    assign grant     = grant_q;

    assign w_req_acc  = bus_reqcyc & bus_reqack;
    assign w_resp_acc = bus_respcyc & bus_respack;

    // ------------------------------------------------------------------
    // Beat counting: cleared by the accepted address beat, advanced by
    // accepted write beats or acknowledged read responses.
    // ------------------------------------------------------------------
    assign w_cnt_clr = (state_q == ADDR) & w_req_acc;
    assign w_cnt_inc = ((state_q == WDATA) & w_req_acc) |
                       (w_resp_phase & w_resp_acc);

    sysbus_beat_counter #(
        .BURST_BEATS (BURST_BEATS)
    ) u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (w_cnt_clr),
        .inc_i  (w_cnt_inc),
        .last_o (w_cnt_last)
    );

    // Round-robin on a tie: the client that did not own the bus last wins.
    always_comb begin
        w_win_idx = 1'b0;
        case (bid)
            2'b01:   w_win_idx = 1'b0;
            2'b10:   w_win_idx = 1'b1;
            2'b11:   w_win_idx = ~last_owner_q;
            default: w_win_idx = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Arbiter FSM. Completion always passes through IDLE with grant_q=0,
    // which guarantees a dead cycle between owners.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bid != 2'b00) begin
                        grant_q <= w_win_idx ? 2'b10 : 2'b01;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_req_acc) begin
                        state_q <= bus_reqtag[WR_BIT] ? WDATA : RRESP;
                    end
                end
                WDATA: begin
                    if (w_req_acc && w_cnt_last) begin
                        state_q      <= IDLE;
                        grant_q      <= 2'b00;
                        last_owner_q <= w_owner;
                    end
                end
                RRESP: begin
                    if (w_resp_acc && w_cnt_last) begin
                        state_q      <= IDLE;
                        grant_q      <= 2'b00;
                        last_owner_q <= w_owner;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule : sysbus_arbiter
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_sysbus_arbiter
// Purpose : Directed self-checking bench for sysbus_arbiter. The bench plays
//           both caches and the Sysbus slave, applying hand-built vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;

    localparam int W = 64;
    localparam int T = 13;

    logic           clk;
    logic           reset;
    logic [1:0]     bid;
    logic [1:0]     grant;
    logic [1:0]     c_reqcyc;
    logic [2*W-1:0] c_req;
    logic [2*T-1:0] c_reqtag;
    logic [1:0]     c_respack;
    logic [1:0]     c_reqack;
    logic [1:0]     c_respcyc;
    logic [W-1:0]   c_resp;
    logic [T-1:0]   c_resptag;
    logic           bus_reqcyc;
    logic [W-1:0]   bus_req;
    logic [T-1:0]   bus_reqtag;
    logic           bus_respack;
    logic           bus_reqack;
    logic           bus_respcyc;
    logic [W-1:0]   bus_resp;
    logic [T-1:0]   bus_resptag;

    int checks   = 0;
    int failures = 0;

    localparam logic [W-1:0] IC_ADDR = 64'h0000_0000_1000_0040;
    localparam logic [W-1:0] DC_ADDR = 64'h0000_0000_2000_0080;

    sysbus_arbiter #(
        .BUS_DATA_WIDTH (W),
        .BUS_TAG_WIDTH  (T),
        .BURST_BEATS    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bid         (bid),
        .grant       (grant),
        .c_reqcyc    (c_reqcyc),
        .c_req       (c_req),
        .c_reqtag    (c_reqtag),
        .c_respack   (c_respack),
        .c_reqack    (c_reqack),
        .c_respcyc   (c_respcyc),
        .c_resp      (c_resp),
        .c_resptag   (c_resptag),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respack (bus_respack),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has just seen grant == g (arbiter in ADDR). Accept the read
    // address, then deliver 8 acknowledged response beats with one
    // unacknowledged stall cycle; grant must hold through beat 7 and drop
    // on the following cycle. The non-owner keeps c_reqcyc high and the
    // owner's bid is replaced by bid_burst.
    task automatic do_read(input logic [1:0] g, input logic [1:0] bid_burst);
        logic stall;
        bus_reqack  = 1'b1;
        c_reqcyc    = g;
        bus_respcyc = 1'b1;          // stray response during ADDR
        c_respack   = g;
        #1;
        chk("addr_stray_respcyc", {62'd0, c_respcyc}, 64'd0);
        chk("addr_stray_respack", {63'd0, bus_respack}, 64'd0);
        chk("addr_reqack_route", {62'd0, c_reqack}, {62'd0, g});
        tick();
        bus_reqack = 1'b0;
        c_reqcyc   = ~g;
        bid        = bid_burst;
        for (int i = 0; i < 9; i++) begin
            stall       = (i == 2);
            bus_respcyc = 1'b1;
            bus_resp    = 64'hA0 + 64'(i);
            c_respack   = stall ? 2'b00 : g;
            #1;
            chk("rd_grant_held", {62'd0, grant}, {62'd0, g});
            chk("rd_respcyc_route", {62'd0, c_respcyc}, {62'd0, g});
            chk("rd_resp_bcast", c_resp, 64'hA0 + 64'(i));
            chk("rd_nonowner_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
            chk("rd_respack", {63'd0, bus_respack}, stall ? 64'd0 : 64'd1);
            tick();
        end
        bus_respcyc = 1'b0;
        c_respack   = 2'b00;
        #1;
        chk("rd_grant_drop", {62'd0, grant}, 64'd0);
    endtask

    initial begin : stim
        logic [9:0] pat;
        reset       = 1'b1;
        bid         = 2'b00;
        c_reqcyc    = 2'b11;
        c_req       = {DC_ADDR, IC_ADDR};
        c_reqtag    = {13'h0123, 13'h0005};
        c_respack   = 2'b11;
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = 64'h55;
        bus_resptag = 13'h0A5A;

        // Reset state: every routed output quiet despite active inputs.
        tick();
        tick();
        chk("rst_grant", {62'd0, grant}, 64'd0);
        chk("rst_bus_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        chk("rst_bus_req", bus_req, 64'd0);
        chk("rst_bus_reqtag", {51'd0, bus_reqtag}, 64'd0);
        chk("rst_bus_respack", {63'd0, bus_respack}, 64'd0);
        chk("rst_c_reqack", {62'd0, c_reqack}, 64'd0);
        chk("rst_c_respcyc", {62'd0, c_respcyc}, 64'd0);
        chk("resptag_bcast", {51'd0, c_resptag}, 64'h0A5A);

        // Stray response in IDLE.
        reset = 1'b0;
        tick();
        chk("idle_stray_respcyc", {62'd0, c_respcyc}, 64'd0);
        chk("idle_stray_respack", {63'd0, bus_respack}, 64'd0);
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b0;
        c_respack   = 2'b00;

        // Lone icache read; dcache bids during the burst and gets the bus
        // after one idle cycle.
        bid = 2'b01;
        tick();
        chk("ic_grant", {62'd0, grant}, 64'd1);
        chk("ic_bus_req", bus_req, IC_ADDR);
        chk("ic_bus_reqtag", {51'd0, bus_reqtag}, 64'h0005);
        chk("ic_bus_reqcyc", {63'd0, bus_reqcyc}, 64'd1);
        do_read(2'b01, 2'b10);
        tick();
        chk("ic_then_dc_grant", {62'd0, grant}, 64'd2);

        // Tie straight after reset goes to dcache, then icache.
        reset = 1'b1;
        bid   = 2'b00;
        tick();
        #1;
        chk("rst2_grant", {62'd0, grant}, 64'd0);
        reset = 1'b0;
        bid   = 2'b11;
        tick();
        chk("tie_grant_dc", {62'd0, grant}, 64'd2);
        chk("tie_bus_req", bus_req, DC_ADDR);
        do_read(2'b10, 2'b11);
        tick();
        chk("tie_rr_grant_ic", {62'd0, grant}, 64'd1);
        do_read(2'b01, 2'b00);

        // dcache write: address plus 8 data beats with two stall cycles.
        c_reqtag = {13'h1ABC, 13'h0005};
        bid      = 2'b10;
        tick();
        chk("wr_grant", {62'd0, grant}, 64'd2);
        chk("wr_bus_reqtag", {51'd0, bus_reqtag}, 64'h1ABC);
        bid        = 2'b00;
        bus_reqack = 1'b1;
        c_reqcyc   = 2'b10;
        tick();
        pat = 10'b1110110111;
        for (int i = 0; i < 10; i++) begin
            bus_reqack         = pat[i];
            c_req[2*W-1:W]     = 64'hD000 + 64'(i);
            c_reqcyc           = 2'b11;
            #1;
            chk("wr_grant_held", {62'd0, grant}, 64'd2);
            chk("wr_bus_req", bus_req, 64'hD000 + 64'(i));
            chk("wr_c_reqack", {62'd0, c_reqack}, pat[i] ? 64'd2 : 64'd0);
            tick();
        end
        bus_reqack = 1'b0;
        #1;
        chk("wr_grant_drop", {62'd0, grant}, 64'd0);
        chk("wr_idle_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        c_req = {DC_ADDR, IC_ADDR};
        c_reqtag = {13'h0123, 13'h0005};

        // Reset during read beat 4, then a clean full read.
        bid = 2'b01;
        tick();
        chk("rr_grant", {62'd0, grant}, 64'd1);
        bid        = 2'b00;
        bus_reqack = 1'b1;
        c_reqcyc   = 2'b01;
        tick();
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        c_respack   = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        reset    = 1'b1;
        c_reqcyc = 2'b11;
        tick();
        chk("midrst_grant", {62'd0, grant}, 64'd0);
        chk("midrst_bus_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        chk("midrst_c_respcyc", {62'd0, c_respcyc}, 64'd0);
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        c_respack   = 2'b00;
        bid         = 2'b01;
        tick();
        chk("post_rst_grant", {62'd0, grant}, 64'd1);
        bid = 2'b00;
        do_read(2'b01, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sysbus_arbiter
`default_nettype wire
